// File: rtl/fft_frame_rx_if.sv
// fft_frame_rx_if: FFT output stream (source_*) and peak result (result_*/peak_*)
// bundle for fft_frame_rx. Clock and reset are plain module ports, not part of this bundle.
// The slave modport is the receiver's view; the master modport is the FFT core / consumer view.
interface fft_frame_rx_if #(
  parameter int FFT_LEN = 1024,
  parameter int DW      = 12
) ();
  localparam int BW = $clog2(FFT_LEN) - 1;

  logic                 source_valid;
  logic                 source_ready;
  logic                 source_sop;
  logic                 source_eop;
  logic [1:0]           source_error;
  logic signed [DW-1:0] source_real;
  logic signed [DW-1:0] source_imag;
  logic                 result_valid;
  logic                 result_ready;
  logic [BW-1:0]        peak_bin;
  logic [2*DW-1:0]      peak_mag;
  logic                 frame_err;

  modport slave (
    input  source_valid, source_sop, source_eop, source_error,
           source_real, source_imag, result_ready,
    output source_ready, result_valid, peak_bin, peak_mag, frame_err
  );

  modport master (
    output source_valid, source_sop, source_eop, source_error,
           source_real, source_imag, result_ready,
    input  source_ready, result_valid, peak_bin, peak_mag, frame_err
  );
endinterface

// File: rtl/fft_frame_rx.sv
// fft_frame_rx: receives FFT output frames and finds the lower-half bin with the
// largest power (re^2 + im^2). Malformed frames (bad length, core error, mid-frame
// restart) are discarded with a one-cycle frame_err pulse.
// Optional feature macro: FFT_RX_SKIP_DC_EN -- when defined, bin 0 is excluded from the search.
module fft_frame_rx #(
  parameter int FFT_LEN = 1024,
  parameter int DW      = 12
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  fft_frame_rx_if.slave  rx
);
  localparam int IW = $clog2(FFT_LEN);
  localparam int BW = IW - 1;
  localparam int MW = 2 * DW;
  // idx_r counts the index of the next expected beat; one spare bit lets it
  // record "FFT_LEN beats already seen without eop".
  localparam logic [IW:0] LAST_IDX = (IW+1)'(FFT_LEN - 1);
  localparam logic [IW:0] FULL_IDX = (IW+1)'(FFT_LEN);
  localparam logic [IW:0] IDX_ONE  = (IW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Unsigned square of a signed sample; |v|^2 <= 2^(2*DW-2) fits in 2*DW-1 bits.
  function automatic logic [MW-2:0] square_f(input logic signed [DW-1:0] v);
    logic signed [MW-1:0] ve;
    logic signed [MW-1:0] p;
    ve = MW'(v);
    p  = ve * ve;
    return p[MW-2:0];
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW:0]   idx_r;
  logic [IW:0]   idx_nxt_s;
  logic          err_seen_r;
  logic          err_nxt_s;
  logic [1:0]    drain_cnt_r;
  logic [1:0]    drain_nxt_s;

  logic          start_s;
  logic          in_frame_s;
  logic          frame_err_s;
  logic          accept_s;
  logic          beat_err_s;
  logic [IW-1:0] beat_idx_s;
  logic          search_s;

  logic          source_ready_r;
  logic          result_valid_r;
  logic          frame_err_r;

  logic          s1_valid_r;
  logic [BW-1:0] s1_bin_r;
  logic [MW-2:0] s1_re2_r;
  logic [MW-2:0] s1_im2_r;
  logic          s2_valid_r;
  logic [BW-1:0] s2_bin_r;
  logic [MW-1:0] s2_mag_r;
  logic [BW-1:0] peak_bin_r;
  logic [MW-1:0] peak_mag_r;

  assign accept_s   = rx.source_valid && source_ready_r;
  assign beat_err_s = (rx.source_error != 2'b00);
  assign beat_idx_s = rx.source_sop ? {IW{1'b0}} : idx_r[IW-1:0];

`ifdef FFT_RX_SKIP_DC_EN
  assign search_s = (beat_idx_s[IW-1] == 1'b0) && (beat_idx_s != {IW{1'b0}});
`else
  assign search_s = (beat_idx_s[IW-1] == 1'b0);
`endif

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and frame bookkeeping decisions for each accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    err_nxt_s   = err_seen_r;
    drain_nxt_s = 2'd0;
    start_s     = 1'b0;
    in_frame_s  = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && rx.source_sop) begin
          start_s    = 1'b1;
          in_frame_s = 1'b1;
          idx_nxt_s  = IDX_ONE;
          err_nxt_s  = beat_err_s;
          if (rx.source_eop) begin
            frame_err_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RECV;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECV: begin
        if (!accept_s) begin
          state_nxt_s = RECV;
        end else if (rx.source_sop) begin
          // restart (or the beat after an over-length frame): drop the old frame, begin anew
          start_s     = 1'b1;
          in_frame_s  = 1'b1;
          frame_err_s = 1'b1;
          idx_nxt_s   = IDX_ONE;
          err_nxt_s   = beat_err_s;
          state_nxt_s = rx.source_eop ? IDLE : RECV;
        end else if (idx_r == FULL_IDX) begin
          frame_err_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (rx.source_eop) begin
          in_frame_s = 1'b1;
          if ((idx_r == LAST_IDX) && !err_seen_r && !beat_err_s) begin
            state_nxt_s = DRAIN;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          in_frame_s  = 1'b1;
          idx_nxt_s   = idx_r + IDX_ONE;
          err_nxt_s   = err_seen_r | beat_err_s;
          state_nxt_s = RECV;
        end
      end
      DRAIN: begin
        // beats accepted here are ignored; wait for the magnitude pipeline to empty
        drain_nxt_s = drain_cnt_r + 2'd1;
        if (drain_cnt_r == 2'd2) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HOLD: begin
        if (rx.result_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Frame index, sticky error flag and drain counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_r       <= {(IW+1){1'b0}};
      err_seen_r  <= 1'b0;
      drain_cnt_r <= 2'd0;
    end else begin
      idx_r       <= idx_nxt_s;
      err_seen_r  <= err_nxt_s;
      drain_cnt_r <= drain_nxt_s;
    end
  end

  // Registered handshake and status outputs, decoded from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      source_ready_r <= 1'b1;
      result_valid_r <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      source_ready_r <= (state_nxt_s != HOLD);
      result_valid_r <= (state_nxt_s == HOLD);
      frame_err_r    <= frame_err_s;
    end
  end

  // Stage 1: square the real and imaginary parts of searched beats.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_bin_r   <= {BW{1'b0}};
      s1_re2_r   <= {(MW-1){1'b0}};
      s1_im2_r   <= {(MW-1){1'b0}};
    end else begin
      s1_valid_r <= in_frame_s && search_s;
      s1_bin_r   <= beat_idx_s[BW-1:0];
      s1_re2_r   <= square_f(rx.source_real);
      s1_im2_r   <= square_f(rx.source_imag);
    end
  end

  // Stage 2: sum of squares; a frame start flushes beats of the abandoned frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s2_valid_r <= 1'b0;
      s2_bin_r   <= {BW{1'b0}};
      s2_mag_r   <= {MW{1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r && !start_s;
      s2_bin_r   <= s1_bin_r;
      s2_mag_r   <= {1'b0, s1_re2_r} + {1'b0, s1_im2_r};
    end
  end

  // Stage 3: keep the strictly largest magnitude so ties resolve to the lowest bin.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      peak_bin_r <= {BW{1'b0}};
      peak_mag_r <= {MW{1'b0}};
    end else if (start_s) begin
      peak_bin_r <= {BW{1'b0}};
      peak_mag_r <= {MW{1'b0}};
    end else if (s2_valid_r && (s2_mag_r > peak_mag_r)) begin
      peak_bin_r <= s2_bin_r;
      peak_mag_r <= s2_mag_r;
    end else begin
      peak_bin_r <= peak_bin_r;
      peak_mag_r <= peak_mag_r;
    end
  end

  assign rx.source_ready = source_ready_r;
  assign rx.result_valid = result_valid_r;
  assign rx.frame_err    = frame_err_r;
  assign rx.peak_bin     = peak_bin_r;
  assign rx.peak_mag     = peak_mag_r;

endmodule

// File: tb/tb_fft_frame_rx.sv
// tb_fft_frame_rx: directed scenarios for fft_frame_rx with FFT_LEN=64, DW=12.
// Expected outcomes (results and frame_err pulses) are queued as each stimulus is
// driven; a negedge monitor queues what the DUT actually produces.
module tb_fft_frame_rx;
  localparam int FFT_LEN = 64;
  localparam int DW      = 12;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  fft_frame_rx_if #(.FFT_LEN(FFT_LEN), .DW(DW)) bus ();

  fft_frame_rx #(.FFT_LEN(FFT_LEN), .DW(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // kind 0 = result, 1 = frame_err pulse; lat < 0 means latency not checked
  typedef struct {
    int     kind;
    int     bin;
    longint mag;
    int     lat;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_eop_cyc = 0;
  logic rv_prev = 1'b0;
  int   fr_re[FFT_LEN];
  int   fr_im[FFT_LEN];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus.frame_err === 1'b1)
      obs_q.push_back('{1, 0, 0, cyc - last_eop_cyc});
    if (bus.result_valid === 1'b1 && rv_prev !== 1'b1)
      obs_q.push_back('{0, int'(bus.peak_bin), longint'(bus.peak_mag), cyc - last_eop_cyc});
    rv_prev <= bus.result_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [1:0] err,
                           input int re, input int im);
    @(negedge sys_clk);
    bus.source_valid = 1'b1;
    bus.source_sop   = sop;
    bus.source_eop   = eop;
    bus.source_error = err;
    bus.source_real  = DW'(re);
    bus.source_imag  = DW'(im);
    @(posedge sys_clk);
    #1;
    if (eop) last_eop_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge sys_clk);
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'b00;
  endtask

  task automatic fill(input int re, input int im);
    for (int i = 0; i < FFT_LEN; i++) begin
      fr_re[i] = re;
      fr_im[i] = im;
    end
  endtask

  task automatic send_frame(input int len, input int err_idx, input bit do_eop);
    for (int i = 0; i < len; i++)
      send_beat(i == 0, do_eop && (i == len - 1), (i == err_idx) ? 2'b01 : 2'b00,
                fr_re[i], fr_im[i]);
  endtask

  task automatic push_exp(input int kind, input int bin, input longint mag, input int lat);
    exp_q.push_back('{kind, bin, mag, lat});
  endtask

  task automatic check_events(input string tag);
    while (exp_q.size() > 0) begin
      ev_t e;
      ev_t o;
      int  t;
      e = exp_q.pop_front();
      t = 0;
      while (obs_q.size() == 0 && t < 300) begin
        @(negedge sys_clk);
        #1;
        t++;
      end
      if (obs_q.size() == 0) begin
        chk({tag, "_timeout"}, obs_q.size(), 1);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_kind"}, o.kind, e.kind);
        if (e.kind == 0) begin
          chk({tag, "_bin"}, o.bin, e.bin);
          chk({tag, "_mag"}, o.mag, e.mag);
        end
        if (e.lat >= 0) chk({tag, "_lat"}, o.lat, e.lat);
      end
    end
    repeat (10) @(negedge sys_clk);
    #1;
    chk({tag, "_extra_events"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_source_ready"}, bus.source_ready, 1);
    chk({tag, "_result_valid"}, bus.result_valid, 0);
    chk({tag, "_peak_bin"}, bus.peak_bin, 0);
    chk({tag, "_peak_mag"}, bus.peak_mag, 0);
    chk({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  initial begin
    sys_rst_n        = 1'b0;
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'b00;
    bus.source_real  = '0;
    bus.source_imag  = '0;
    bus.result_ready = 1'b1;

    // reset values
    repeat (3) @(negedge sys_clk);
    #1;
    chk_reset_vals("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // clean frame, plus a sop beat during DRAIN that must be dropped silently
    fill(1, 1);
    fr_re[5] = 100; fr_im[5] = -200;
    push_exp(0, 5, 50000, 3);
    send_frame(64, -1, 1);
    send_beat(1'b1, 1'b0, 2'b00, 7, 7);
    idle();
    check_events("clean");

    // tie resolves to lowest index; upper-half bin ignored
    fill(0, 0);
    fr_re[3] = 30;   fr_im[3] = 40;
    fr_re[9] = 30;   fr_im[9] = 40;
    fr_re[40] = 500; fr_im[40] = 0;
    push_exp(0, 3, 2500, 3);
    send_frame(64, -1, 1);
    idle();
    check_events("tie");

    // DC bin handling
    fill(0, 0);
    fr_re[0] = 1000;
    fr_re[2] = 10;
`ifdef FFT_RX_SKIP_DC_EN
    push_exp(0, 2, 100, 3);
`else
    push_exp(0, 0, 1000000, 3);
`endif
    send_frame(64, -1, 1);
    idle();
    check_events("dc");

    // short frame: eop at index 40, then a clean frame
    fill(1, 1);
    fr_re[5] = 100; fr_im[5] = -200;
    push_exp(1, 0, 0, 0);
    send_frame(41, -1, 1);
    idle();
    check_events("short");
    push_exp(0, 5, 50000, 3);
    send_frame(64, -1, 1);
    idle();
    check_events("after_short");

    // core error on index 7
    push_exp(1, 0, 0, 0);
    send_frame(64, 7, 1);
    idle();
    check_events("src_error");

    // mid-frame sop at index 20 restarts into a full 64-beat frame
    fill(1, 1);
    fr_re[12] = -300; fr_im[12] = 400;
    push_exp(1, 0, 0, -1);
    push_exp(0, 12, 250000, 3);
    send_frame(20, -1, 0);
    send_frame(64, -1, 1);
    idle();
    check_events("restart");

    // 64 beats without eop; the 65th beat (sop) is a length error and a new frame
    push_exp(1, 0, 0, -1);
    push_exp(0, 12, 250000, 3);
    send_frame(64, -1, 0);
    send_frame(64, -1, 1);
    idle();
    check_events("overlength");

    // full-scale magnitude, last searched bin, first ignored bin
    fill(0, 0);
    fr_re[17] = -2048; fr_im[17] = -2048;
    fr_re[31] = 2047;  fr_im[31] = 2047;
    fr_re[32] = -2048; fr_im[32] = -2048;
    push_exp(0, 17, 8388608, 3);
    send_frame(64, -1, 1);
    idle();
    check_events("fullscale");

    // backpressure: result held while result_ready is low
    fill(1, 1);
    fr_re[5] = 100; fr_im[5] = -200;
    bus.result_ready = 1'b0;
    push_exp(0, 5, 50000, 3);
    send_frame(64, -1, 1);
    idle();
    check_events("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      #1;
      chk("bp_source_ready", bus.source_ready, 0);
      chk("bp_result_valid", bus.result_valid, 1);
      chk("bp_peak_bin", bus.peak_bin, 5);
      chk("bp_peak_mag", bus.peak_mag, 50000);
    end
    @(negedge sys_clk);
    bus.result_ready = 1'b1;
    @(negedge sys_clk);
    #1;
    chk("bp_release_valid", bus.result_valid, 0);
    chk("bp_release_ready", bus.source_ready, 1);
    obs_q.delete();

    // reset asserted mid-RECV
    fill(1, 1);
    send_frame(20, -1, 0);
    @(negedge sys_clk);
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    sys_rst_n        = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    #1;
    chk("midrst_no_events", obs_q.size(), 0);
    obs_q.delete();
    fr_re[5] = 100; fr_im[5] = -200;
    push_exp(0, 5, 50000, 3);
    send_frame(64, -1, 1);
    idle();
    check_events("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
